// File: rtl/fuzzy_pkg.sv
// Shared constants and types for the centroid defuzzifier.
// Latency: n/a (package only).
// Backpressure: n/a.
package fuzzy_pkg;

    localparam int N_REGRAS = 16;
    localparam int W        = 8;
    localparam int IDX_W    = 4;
    // Sized for 16 terms of 255*255 and 16*255 without wrap.
    localparam int NUM_W    = 20;
    localparam int DEN_W    = 12;
    localparam logic [W-1:0] SAIDA_PADRAO = 8'd128;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ACUMULA = 2'd1,
        DIVIDE  = 2'd2,
        PRONTO  = 2'd3
    } estado_t;

endpackage

// File: rtl/defuzzy_centroide_if.sv
// Rule-term input bus and crisp-output bus of the centroid defuzzifier.
// Latency: n/a (wiring only).
// Backpressure: none; the producer watches ocupado and the consumer takes saida_valida as a pulse.
// Signals: inicio/regra_valida/regra_idx/peso/centroide/fim_regras (master -> slave),
//          saida_defuzzy/saida_valida/ocupado/erro_regra (slave -> master).
interface defuzzy_centroide_if
    import fuzzy_pkg::*;
#(
    parameter int DW = W
);
    logic             inicio;
    logic             regra_valida;
    logic [IDX_W-1:0] regra_idx;
    logic [DW-1:0]    peso;
    logic [DW-1:0]    centroide;
    logic             fim_regras;
    logic [DW-1:0]    saida_defuzzy;
    logic             saida_valida;
    logic             ocupado;
    logic             erro_regra;

    modport master (
        output inicio, regra_valida, regra_idx, peso, centroide, fim_regras,
        input  saida_defuzzy, saida_valida, ocupado, erro_regra
    );

    modport slave (
        input  inicio, regra_valida, regra_idx, peso, centroide, fim_regras,
        output saida_defuzzy, saida_valida, ocupado, erro_regra
    );
endinterface

// File: rtl/div_serial.sv
// Serial restoring divider, one quotient bit per clock, truncating.
// Latency: o_done pulses NUM_BITS cycles after i_start; the first bit is resolved on the start edge.
// Backpressure: none; i_start restarts immediately and discards any division in flight.
// Ports: clk, rst_n, i_start, i_dividend, i_divisor -> o_quotient, o_done.
module div_serial
    import fuzzy_pkg::*;
#(
    parameter int NUM_BITS = NUM_W,
    parameter int DEN_BITS = DEN_W
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic [NUM_BITS-1:0] i_dividend,
    input  logic [DEN_BITS-1:0] i_divisor,
    output logic [NUM_BITS-1:0] o_quotient,
    output logic                o_done
);
    localparam int CNT_W = $clog2(NUM_BITS + 1);
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(NUM_BITS - 1);

    logic [DEN_BITS-1:0] r_rem, r_den;
    logic [NUM_BITS-1:0] r_quo;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy, r_done;

    logic [DEN_BITS-1:0] w_rem_src, w_den_src, w_rem_next;
    logic [NUM_BITS-1:0] w_quo_src, w_quo_next;
    logic [DEN_BITS:0]   w_shift;
    logic                w_bit;

    // r_quo holds the dividend bits not yet consumed at the top and the
    // quotient bits already produced at the bottom.
    always_comb begin
        w_rem_src  = i_start ? '0         : r_rem;
        w_quo_src  = i_start ? i_dividend : r_quo;
        w_den_src  = i_start ? i_divisor  : r_den;
        w_shift    = {w_rem_src, w_quo_src[NUM_BITS-1]};
        w_bit      = (w_shift >= {1'b0, w_den_src});
        // The remainder is always below the divisor, so DEN_BITS bits suffice.
        w_rem_next = w_bit ? DEN_BITS'(w_shift - {1'b0, w_den_src}) : w_shift[DEN_BITS-1:0];
        w_quo_next = {w_quo_src[NUM_BITS-2:0], w_bit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_den  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_rem  <= w_rem_next;
            r_quo  <= w_quo_next;
            r_den  <= i_divisor;
            r_cnt  <= CNT_W'(1);
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            r_rem  <= w_rem_next;
            r_quo  <= w_quo_next;
            r_cnt  <= r_cnt + CNT_W'(1);
            r_busy <= (r_cnt != ULTIMO);
            r_done <= (r_cnt == ULTIMO);
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_quotient = r_quo;
    assign o_done     = r_done;
endmodule

// File: rtl/defuzzy_centroide.sv
// Centroid defuzzifier: sum(peso*centroide)/sum(peso) over one frame of rule terms.
// Latency: saida_valida 21 cycles after the last term (1 cycle when no rule fired).
// Backpressure: none; ocupado is advisory, inicio aborts any frame or division in progress.
// Ports: clk_0, Srst (async, active-low), bus (defuzzy_centroide_if.slave).
module defuzzy_centroide #(
    parameter int               N_REGRAS     = fuzzy_pkg::N_REGRAS,
    parameter int               W            = fuzzy_pkg::W,
    parameter logic [W-1:0]     SAIDA_PADRAO = fuzzy_pkg::SAIDA_PADRAO
)(
    input  logic                clk_0,
    input  logic                Srst,
    defuzzy_centroide_if.slave  bus
);
    import fuzzy_pkg::*;

    estado_t             r_estado, w_prox;
    logic [NUM_W-1:0]    r_num, w_num_base, w_num_next;
    logic [DEN_W-1:0]    r_den, w_den_base, w_den_next;
    logic [N_REGRAS-1:0] r_mask, w_mask_base, w_mask_next;
    logic [W-1:0]        r_saida;
    logic                r_erro;

    logic [2*W-1:0]      w_prod;
    logic                w_janela, w_dup, w_soma, w_fim, w_fim_zero, w_inicia_div, w_carrega_div;
    logic [NUM_W-1:0]    w_quo;
    logic                w_div_done;
    logic [W-1:0]        w_quo_sat;

    // Datapath: inicio clears first, so a term presented with inicio starts the new frame.
    always_comb begin
        w_num_base    = bus.inicio ? '0 : r_num;
        w_den_base    = bus.inicio ? '0 : r_den;
        w_mask_base   = bus.inicio ? '0 : r_mask;
        w_janela      = bus.regra_valida && (bus.inicio || (r_estado == ACUMULA));
        w_dup         = w_janela && w_mask_base[bus.regra_idx];
        w_soma        = w_janela && !w_dup;
        w_prod        = bus.peso * bus.centroide;
        w_num_next    = w_soma ? (w_num_base + NUM_W'(w_prod)) : w_num_base;
        w_den_next    = w_soma ? (w_den_base + DEN_W'(bus.peso)) : w_den_base;
        w_mask_next   = w_soma ? (w_mask_base | (N_REGRAS'(1) << bus.regra_idx)) : w_mask_base;
        // A duplicate term is dropped but its fim_regras still closes the frame.
        w_fim         = w_janela && bus.fim_regras;
        w_inicia_div  = w_fim && (w_den_next != '0);
        w_fim_zero    = w_fim && (w_den_next == '0);
        w_carrega_div = (r_estado == DIVIDE) && !bus.inicio && w_div_done;
        w_quo_sat     = (|w_quo[NUM_W-1:W]) ? '1 : w_quo[W-1:0];
    end

    // FSM: next state
    always_comb begin
        w_prox = r_estado;
        if (w_fim) begin
            w_prox = w_inicia_div ? DIVIDE : PRONTO;
        end else if (bus.inicio) begin
            w_prox = ACUMULA;
        end else begin
            case (r_estado)
                DIVIDE:  if (w_div_done) w_prox = PRONTO;
                PRONTO:  w_prox = OCIOSO;
                default: w_prox = r_estado;
            endcase
        end
    end

    // FSM: state register plus frame accumulators
    always_ff @(posedge clk_0 or negedge Srst) begin
        if (!Srst) begin
            r_estado <= OCIOSO;
            r_num    <= '0;
            r_den    <= '0;
            r_mask   <= '0;
            r_saida  <= SAIDA_PADRAO;
            r_erro   <= 1'b0;
        end else begin
            r_estado <= w_prox;
            r_num    <= w_num_next;
            r_den    <= w_den_next;
            r_mask   <= w_mask_next;
            r_erro   <= w_dup;
            if (w_fim_zero) begin
                r_saida <= SAIDA_PADRAO;
            end else if (w_carrega_div) begin
                r_saida <= w_quo_sat;
            end
        end
    end

    // FSM: outputs
    always_comb begin
        bus.ocupado      = (r_estado == ACUMULA) || (r_estado == DIVIDE);
        bus.saida_valida = (r_estado == PRONTO);
    end

    assign bus.saida_defuzzy = r_saida;
    assign bus.erro_regra    = r_erro;

    div_serial #(
        .NUM_BITS (NUM_W),
        .DEN_BITS (DEN_W)
    ) u_div (
        .clk        (clk_0),
        .rst_n      (Srst),
        .i_start    (w_inicia_div),
        .i_dividend (w_num_next),
        .i_divisor  (w_den_next),
        .o_quotient (w_quo),
        .o_done     (w_div_done)
    );
endmodule

// File: doc/defuzzy_centroide.md
DEFUZZY_CENTROIDE -- requirements
Module: defuzzy_centroide

Interface
REQ-001 SHALL have parameter N_REGRAS, default 16, number of rules per inference frame.
REQ-002 SHALL have parameter W, default 8, width of firing strength, centroid and output.
REQ-003 SHALL have parameter SAIDA_PADRAO, default 8'd128, output when no rule fires.
REQ-004 clk_0  in  1  single system clock; all state on rising edge.
REQ-005 Srst  in  1  reset, asynchronous, active-low.
REQ-006 inicio  in  1  start of inference frame; clears accumulators.
REQ-007 regra_valida  in  1  one rule term presented this cycle.
REQ-008 regra_idx  in  4  rule index of presented term.
REQ-009 peso  in  W  rule firing strength (min of antecedent memberships).
REQ-010 centroide  in  W  consequent centroid of that rule.
REQ-011 fim_regras  in  1  qualifies regra_valida: last term of the frame.
REQ-012 saida_defuzzy  out  W  crisp controller output, held between results.
REQ-013 saida_valida  out  1  one-cycle pulse, new saida_defuzzy.
REQ-014 ocupado  out  1  high in ACUMULA and DIVIDE.
REQ-015 erro_regra  out  1  one-cycle pulse, duplicate regra_idx in frame.

Function
REQ-016 FSM states SHALL be OCIOSO, ACUMULA, DIVIDE, PRONTO.
REQ-017 OCIOSO: regra_valida ignored; inicio -> ACUMULA.
REQ-018 inicio in any state SHALL clear num (20 b), den (12 b), 16-bit index mask and go to ACUMULA; an in-progress division is aborted with no saida_valida.
REQ-019 ACUMULA, regra_valida with mask[regra_idx]=0: num += peso*centroide, den += peso, mask bit set.
REQ-020 ACUMULA, regra_valida with mask[regra_idx]=1: term discarded, erro_regra pulses next cycle; fim_regras still honoured.
REQ-021 inicio and regra_valida in same cycle: clear first, then that term is accumulated.
REQ-022 Accepted term with fim_regras=1: next state DIVIDE if updated den!=0, else PRONTO with result SAIDA_PADRAO.
REQ-023 DIVIDE: serial restoring division num/den, one quotient bit per cycle, exactly 20 cycles, truncating.
REQ-024 Quotient SHALL saturate to 2^W-1 if above (unreachable for valid input, required anyway).
REQ-025 PRONTO: saida_defuzzy loaded, saida_valida high for that one cycle, then OCIOSO.
REQ-026 Latency: last term accepted at cycle t -> saida_valida at t+21 (den!=0) or t+1 (den=0).
REQ-027 Accumulator widths SHALL hold 16 terms of 255*255 (1 040 400) and 16*255 (4080) without wrap.
REQ-028 Terms beyond N_REGRAS accepted in one frame are impossible by the mask; no extra check needed.

Reset
REQ-029 Srst low SHALL force: state OCIOSO, num=0, den=0, mask=0, saida_defuzzy=SAIDA_PADRAO, saida_valida=0, ocupado=0, erro_regra=0.
REQ-030 Reset mid-frame or mid-DIVIDE SHALL discard the frame; no saida_valida after release until a new complete frame.

Structure
REQ-031 Package fuzzy_pkg SHALL hold state encoding, N_REGRAS, W, accumulator widths and SAIDA_PADRAO.
REQ-032 Serial divider SHALL be sub-module div_serial (start, dividend, divisor -> quotient, done); FSM, multiply-accumulate and mask in top.

Verification
REQ-033 inicio; idx0 w=100 c=50; idx1 w=100 c=150 fim -> saida_defuzzy=100, saida_valida 21 cycles after last term.
REQ-034 inicio; idx0..15 all w=0, fim on idx15 -> 128 one cycle after last term, no DIVIDE entry.
REQ-035 inicio; idx0..15 w=255 c=255 -> 255, no accumulator wrap.
REQ-036 inicio; idx3 w=200 c=10; idx3 w=50 c=250 fim -> erro_regra pulse, result 10.
REQ-037 frame started, inicio asserted 5 cycles into DIVIDE, then idx0 w=64 c=200 fim -> only one saida_valida, value 200.
REQ-038 Srst low during ACUMULA -> outputs at reset values, no saida_valida until next full frame.
